// File: rtl/gaussian_blur_pkg.sv
// Shared definitions for the 3x3 Gaussian blur stage: FSM states, kernel
// weights and arithmetic widths.
package gaussian_pkg;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  localparam int PIX_W = 8;
  localparam int SUM_W = 12;

  localparam logic [SUM_W-1:0] K_CORNER = 12'd1;
  localparam logic [SUM_W-1:0] K_EDGE   = 12'd2;
  localparam logic [SUM_W-1:0] K_CENTRE = 12'd4;

endpackage

// File: rtl/gaussian_blur_if.sv
// FIFO-facing signals of the blur stage: input FIFO pop side and output FIFO push side.
interface gaussian_blur_if;
  import gaussian_pkg::*;

  logic             in_rd_en;
  logic             in_empty;
  logic [PIX_W-1:0] in_dout;
  logic             out_wr_en;
  logic             out_full;
  logic [PIX_W-1:0] out_din;

  modport master (
    output in_rd_en, out_wr_en, out_din,
    input  in_empty, in_dout, out_full
  );

  modport slave (
    input  in_rd_en, out_wr_en, out_din,
    output in_empty, in_dout, out_full
  );

endinterface

// File: rtl/gaussian_blur_window_shift_reg.sv
// Two-rows-plus-two pixel delay line; exposes the eight stored taps of the 3x3 window
// (the ninth window pixel is the live input).
module window_shift_reg
  import gaussian_pkg::*;
#(
  parameter int ROW_LEN = 720,
  parameter int DEPTH   = 2*ROW_LEN+2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] taps [8]
);

  logic [DEPTH-1:0][PIX_W-1:0] sr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sr <= '0;
    end else if (shift) begin
      sr <= {sr[DEPTH-2:0], din};
    end
  end

  // taps[0..1]: bottom row, taps[2..4]: middle row, taps[5..7]: top row
  assign taps[0] = sr[0];
  assign taps[1] = sr[1];
  assign taps[2] = sr[ROW_LEN-1];
  assign taps[3] = sr[ROW_LEN];
  assign taps[4] = sr[ROW_LEN+1];
  assign taps[5] = sr[2*ROW_LEN-1];
  assign taps[6] = sr[2*ROW_LEN];
  assign taps[7] = sr[2*ROW_LEN+1];

endmodule

// File: rtl/gaussian_blur.sv
// 3x3 Gaussian blur between two FIFOs: one blurred pixel pushed per pixel popped,
// frame border forced to zero, window latency of WIDTH+1 pixels.
module gaussian_blur
  import gaussian_pkg::*;
#(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic            clock,
  input  logic            reset,
  gaussian_blur_if.master bus
);

  localparam int TOTAL = WIDTH*HEIGHT;
  localparam int CNT_W = $clog2(TOTAL+1);
  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  state_t           state, next_state;
  logic [CNT_W-1:0] in_cnt;
  logic [COL_W-1:0] out_col;
  logic [ROW_W-1:0] out_row;
  logic             pop, push;
  logic [PIX_W-1:0] pix;
  logic [PIX_W-1:0] win [8];
  logic [SUM_W-1:0] sum;
  logic             border, last_out;

  function automatic logic [SUM_W-1:0] weigh(input logic [PIX_W-1:0] p,
                                             input logic [SUM_W-1:0] k);
    return SUM_W'(p) * k;
  endfunction

  // Divide by 16 by dropping the low nibble; no rounding.
  function automatic logic [PIX_W-1:0] scale_sum(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:SUM_W-PIX_W];
  endfunction

  window_shift_reg #(
    .ROW_LEN (WIDTH),
    .DEPTH   (2*WIDTH+2)
  ) u_window (
    .clock (clock),
    .reset (reset),
    .shift (pop),
    .din   (bus.in_dout),
    .taps  (win)
  );

  assign sum = weigh(bus.in_dout, K_CORNER) + weigh(win[0], K_EDGE)   + weigh(win[1], K_CORNER)
             + weigh(win[2], K_EDGE)        + weigh(win[3], K_CENTRE) + weigh(win[4], K_EDGE)
             + weigh(win[5], K_CORNER)      + weigh(win[6], K_EDGE)   + weigh(win[7], K_CORNER);

  assign border   = (out_row == '0) || (out_row == ROW_W'(HEIGHT-1)) ||
                    (out_col == '0) || (out_col == COL_W'(WIDTH-1));
  assign last_out = (out_row == ROW_W'(HEIGHT-1)) && (out_col == COL_W'(WIDTH-1));

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    push       = 1'b0;
    pix        = '0;
    if (reset) begin
      case (state)
        S_FILL: begin
          pop = !bus.in_empty;
          if (!bus.in_empty && in_cnt == CNT_W'(WIDTH)) next_state = S_RUN;
        end
        S_RUN: begin
          // Pop and push strictly together so input and output stay in lockstep.
          if (!bus.in_empty && !bus.out_full) begin
            pop  = 1'b1;
            push = 1'b1;
            pix  = border ? '0 : scale_sum(sum);
            if (in_cnt == CNT_W'(TOTAL-1)) next_state = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!bus.out_full) begin
            push = 1'b1;
            if (last_out) next_state = S_FILL;
          end
        end
        default: next_state = S_FILL;
      endcase
    end
  end

  assign bus.in_rd_en  = pop;
  assign bus.out_wr_en = push;
  assign bus.out_din   = pix;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= S_FILL;
      in_cnt  <= '0;
      out_col <= '0;
      out_row <= '0;
    end else begin
      state <= next_state;
      if (next_state == S_FILL && state != S_FILL) begin
        in_cnt  <= '0;
        out_col <= '0;
        out_row <= '0;
      end else begin
        if (pop) in_cnt <= in_cnt + CNT_W'(1);
        if (push) begin
          if (out_col == COL_W'(WIDTH-1)) begin
            out_col <= '0;
            out_row <= out_row + ROW_W'(1);
          end else begin
            out_col <= out_col + COL_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gaussian_blur.sv
// Self-checking bench for gaussian_blur on an 8x6 frame: FIFO models, a 2-D
// convolution reference, and directed images with hand-derived expectations.
module tb_gaussian_blur;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W*H;

  logic clock;
  logic reset;
  gaussian_blur_if bus();

  gaussian_blur #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] img     [N];
  logic [7:0] gold    [N];
  logic [7:0] got     [N];
  logic [7:0] ref_out [N];
  logic [7:0] in_q  [$];
  logic [7:0] exp_q [$];

  bit pop_pend     = 1'b0;
  bit ignore_model = 1'b1;
  bit stall_active = 1'b0;
  int frame_pops   = 0;
  int frame_writes = 0;
  int first_write_pops = -1;

  function automatic void check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: direct 2-D convolution of the whole frame, border forced to zero.
  task automatic build_gold();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int s;
        s = 0;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
          gold[r*W+c] = 8'd0;
        end else begin
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) * int'(img[(r+dr)*W + (c+dc)]);
          gold[r*W+c] = 8'(s / 16);
        end
      end
    end
  endtask

  // Output monitor / scoreboard, sampled mid-cycle.
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      check("reset_rd_en", int'(bus.in_rd_en), 0);
      check("reset_wr_en", int'(bus.out_wr_en), 0);
      check("reset_din", int'(bus.out_din), 0);
      pop_pend = 1'b0;
    end else begin
      check("rd_while_empty", int'(bus.in_rd_en & bus.in_empty), 0);
      check("wr_while_full", int'(bus.out_wr_en & bus.out_full), 0);
      if (stall_active) check("rd_during_stall", int'(bus.in_rd_en), 0);
      pop_pend = bus.in_rd_en;
      if (bus.in_rd_en) frame_pops++;
      if (bus.out_wr_en) begin
        if (first_write_pops < 0) first_write_pops = frame_pops;
        if (frame_writes < N) got[frame_writes] = bus.out_din;
        frame_writes++;
        if (!ignore_model) begin
          if (exp_q.size() == 0) check("extra_write", frame_writes, N);
          else check("pixel", int'(bus.out_din), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(input int cyc, input int stall_at, input bit bubbles);
    bit bub;
    @(posedge clock);
    #1;
    if (pop_pend && in_q.size() > 0) void'(in_q.pop_front());
    pop_pend = 1'b0;
    stall_active = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 5);
    bub = bubbles && (stall_at >= 0) && (cyc >= stall_at + 5) && ($urandom_range(0, 2) == 0);
    bus.out_full = stall_active;
    bus.in_empty = (in_q.size() == 0) || bub;
    bus.in_dout  = (in_q.size() > 0) ? in_q[0] : 8'd0;
  endtask

  task automatic load_frame();
    build_gold();
    in_q.delete();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      in_q.push_back(img[i]);
      exp_q.push_back(gold[i]);
    end
    frame_pops = 0;
    frame_writes = 0;
    first_write_pops = -1;
    ignore_model = 1'b0;
    stall_active = 1'b0;
    bus.out_full = 1'b0;
    bus.in_empty = 1'b0;
    bus.in_dout  = in_q[0];
  endtask

  task automatic run_frame(input int stall_at, input bit bubbles);
    int cyc;
    load_frame();
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 3000) begin
      tick(cyc, stall_at, bubbles);
      cyc++;
    end
    check("frame_done_remaining", exp_q.size(), 0);
    for (int k = 0; k < 4; k++) tick(cyc + k, -1, 1'b0);
    check("write_count", frame_writes, N);
    check("pop_count", frame_pops, N);
  endtask

  initial begin
    // Reset with a non-empty input FIFO: enables must still stay low.
    reset = 1'b0;
    bus.in_empty = 1'b0;
    bus.in_dout  = 8'hAA;
    bus.out_full = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    bus.in_empty = 1'b1;

    // Flat 100 image.
    for (int i = 0; i < N; i++) img[i] = 8'd100;
    run_frame(-1, 1'b0);
    check("first_write_on_pop", first_write_pops, 10);
    check("flat_gold_interior", int'(gold[1*W+1]), 100);
    check("flat_gold_border", int'(gold[0]), 0);
    check("flat_out_interior", int'(got[3*W+4]), 100);
    check("flat_out_border", int'(got[5*W+7]), 0);

    // Single impulse at row 2, column 3.
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    img[2*W+3] = 8'd160;
    run_frame(-1, 1'b0);
    check("imp_gold_centre", int'(gold[2*W+3]), 40);
    check("imp_gold_up", int'(gold[1*W+3]), 20);
    check("imp_gold_left", int'(gold[2*W+2]), 20);
    check("imp_gold_diag", int'(gold[3*W+4]), 10);
    check("imp_out_centre", int'(got[2*W+3]), 40);
    check("imp_out_down", int'(got[3*W+3]), 20);
    check("imp_out_right", int'(got[2*W+4]), 20);
    check("imp_out_diag", int'(got[1*W+2]), 10);
    check("imp_out_far", int'(got[4*W+6]), 0);

    // Saturated image: maximum sum 4080 must not wrap.
    for (int i = 0; i < N; i++) img[i] = 8'd255;
    run_frame(-1, 1'b0);
    check("max_gold_interior", int'(gold[2*W+2]), 255);
    check("max_out_interior", int'(got[3*W+3]), 255);

    // Checkerboard: every interior window sums to 2040.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r*W+c] = ((r + c) % 2 == 0) ? 8'd255 : 8'd0;
    run_frame(-1, 1'b0);
    check("chk_gold_even", int'(gold[1*W+1]), 127);
    check("chk_gold_odd", int'(gold[1*W+2]), 127);
    check("chk_out_odd", int'(got[2*W+3]), 127);

    // Ramp-like image without stalls, kept as the reference sequence.
    for (int i = 0; i < N; i++) img[i] = 8'((i*37 + 11) & 255);
    run_frame(-1, 1'b0);
    for (int i = 0; i < N; i++) ref_out[i] = got[i];

    // Same image with an output stall mid-run followed by input bubbles.
    run_frame(15, 1'b1);
    for (int i = 0; i < N; i++) check("stall_vs_nostall", int'(got[i]), int'(ref_out[i]));

    // Partial impulse frame interrupted by a two-cycle reset.
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    img[2*W+3] = 8'd160;
    load_frame();
    for (int k = 0; k < 20; k++) tick(k, -1, 1'b0);
    ignore_model = 1'b1;
    reset = 1'b0;
    tick(20, -1, 1'b0);
    tick(21, -1, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < N; i++) img[i] = 8'((i*37 + 11) & 255);
    run_frame(-1, 1'b0);
    check("post_reset_first_write", first_write_pops, 10);
    for (int i = 0; i < N; i++) check("post_reset_vs_ref", int'(got[i]), int'(ref_out[i]));

    // Back-to-back frame with no gap.
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r*W+c] = ((r + c) % 2 == 0) ? 8'd255 : 8'd0;
    run_frame(-1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gaussian_blur.md
Name: gaussian_blur

Overview:
- Downstream neighbour of the grayscale stage in the Hough-transform pipeline.
- Reads 8-bit grayscale pixels from a FIFO in raster order and applies a 3x3 Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16.
- Writes one 8-bit blurred pixel to an output FIFO for every input pixel; border pixels are forced to 0.
- Feeds the Sobel/edge stage.

Parameters:
- WIDTH, 720, pixels per row (>= 3)
- HEIGHT, 540, rows per frame (>= 3)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset; state clears on a clock edge with reset==0
- in_rd_en  out  1  pop request to input FIFO
- in_empty  in  1  input FIFO empty
- in_dout  in  8  grayscale pixel at head of input FIFO
- out_wr_en  out  1  push request to output FIFO
- out_full  in  1  output FIFO full
- out_din  out  8  blurred pixel

Behaviour:
- Reset (reset==0 at a clock edge): state=S_FILL, all counters=0, window shift register all 0.
- While reset==0: in_rd_en=0, out_wr_en=0, out_din=0.
- Window storage: shift register of 2*WIDTH+2 pixels.
  - sr[0] holds input p-1, sr[k] holds input p-1-k, where p is the index of the pixel at in_dout.
  - The 3x3 window is: bottom row {in_dout, sr[0], sr[1]}; middle row sr[WIDTH-1..WIDTH+1]; top row sr[2*WIDTH-1..2*WIDTH+1].
  - The centre pixel is input index p-WIDTH-1.
  - On each pop, in_dout shifts into sr[0].
- Arithmetic: weighted sum is 12 bits unsigned (max 4080). Output is sum[11:4], truncating with no rounding.
- Output counters out_row and out_col track the centre pixel. If out_row is 0 or HEIGHT-1, or out_col is 0 or WIDTH-1, out_din=0 regardless of the sum.
- S_FILL:
  - in_rd_en = !in_empty; out_wr_en=0.
  - Each pop shifts and increments in_cnt.
  - After WIDTH+1 pops, go to S_RUN. out_row and out_col are 0.
- S_RUN:
  - When in_empty==0 and out_full==0 in the same cycle: in_rd_en=1 and out_wr_en=1. out_din is computed combinationally from the current window, so there is zero extra latency. Shift, increment in_cnt, and advance out_col/out_row (col wraps at WIDTH-1 and increments row).
  - If either in_empty==1 or out_full==1: both enables are 0 and nothing advances. There is never a read without a write or a write without a read.
  - The transfer that pops input index WIDTH*HEIGHT-1 moves the block to S_FLUSH.
- S_FLUSH:
  - Emits the remaining WIDTH+1 outputs. All of them are border pixels, so out_din=0.
  - One output per cycle while out_full==0; in_rd_en=0.
  - After WIDTH+1 writes, clear all counters and go to S_FILL. The next frame starts at pixel 0; shift-register contents need not be cleared.
- Totals: exactly WIDTH*HEIGHT writes per frame. Latency is WIDTH+1 pixel transfers from the first pop to the first push.
- Reset mid-frame: any partial frame is discarded, and the next pixel after reset is treated as (0,0).
- Default/illegal state: next state is S_FILL, both enables 0.

Decomposition:
- Shared package gaussian_pkg holds:
  - state typedef {S_FILL, S_RUN, S_FLUSH}
  - kernel weight constants
  - SUM_W=12 constant
- WIDTH and HEIGHT remain module parameters, so the frame size stays overridable per instance.
- One sub-module, window_shift_reg (parameter DEPTH=2*WIDTH+2, 8-bit, shift-enable, parallel taps), holds the shift register.
- The FSM, counters and kernel adder tree stay in gaussian_blur.

Test Plan:
- WIDTH=8, HEIGHT=6, all pixels 100, FIFOs never stall -> 48 writes; the 24 interior pixels equal 100 and the 24 border pixels equal 0; first write occurs on the 10th pop.
- Single impulse 160 at (2,3), rest 0 -> out(2,3)=40, out(1,3)=out(3,3)=out(2,2)=out(2,4)=20, diagonals=10, all else 0.
- All pixels 255 -> interior 255 (no overflow). Alternating 0/255 checkerboard -> interior values of 127 (sum 2040) or 127 per parity, checked against a golden model.
- out_full held 1 for 5 cycles mid-S_RUN, then random in_empty bubbles -> no pops or pushes while stalled; output sequence is bit-identical to the no-stall run; count stays 48.
- Two back-to-back frames, with reset driven low for 2 cycles midway through frame 1 and then a fresh frame -> enables are 0 during reset; the post-reset frame output matches the golden model with exactly 48 writes.
